tx_frame_sched: RTL
===================

// Module: tx_frame_sched
//
// PURPOSE
// - Frame-aligned scheduler that shares the Tx video output between two AXI4-Stream video sources.
//   - Source 0: live pixel stream.
//   - Source 1: synthetic test-pattern stream.
// - Sits in front of the Tx pattern/colour stage. Drives one m_axis_video port.
// - A requested source change takes effect only at a start-of-frame (tuser) boundary, so no frame is ever split.
// - Reports the active source, a frame counter and the line count of the last completed frame.
//
// PARAMETERS
// - DATA_W        32  tdata width of all streams
// - FCNT_W        16  frame counter width
// - LCNT_W        12  line counter width
// - DROP_INACTIVE  1  1: inactive source tready=1 (beats discarded); 0: inactive tready=0
//
// PORTS
// - clk                  in   1       single clock; all logic on rising edge
// - rst                  in   1       reset, asynchronous, active-high
// - sel_req              in   1       requested source (0 live, 1 synthetic); level, sampled every cycle
// - s0_axis_video_tdata  in   DATA_W  source 0 data
// - s0_axis_video_tvalid in   1       source 0 valid
// - s0_axis_video_tready out  1       source 0 ready
// - s0_axis_video_tlast  in   1       source 0 end of line
// - s0_axis_video_tuser  in   1       source 0 start of frame
// - s1_axis_video_*      --   --      source 1; same five signals as s0
// - m_axis_video_tdata   out  DATA_W  output data
// - m_axis_video_tvalid  out  1       output valid
// - m_axis_video_tready  in   1       output ready
// - m_axis_video_tlast   out  1       output end of line
// - m_axis_video_tuser   out  1       output start of frame
// - sel_active           out  1       source currently owning the output
// - switch_pending       out  1       sel_req differs from sel_active; waiting for a frame boundary
// - frame_cnt            out  FCNT_W  frames started on output (wraps)
// - last_lines           out  LCNT_W  tlast count of the previous output frame
//
// BEHAVIOUR
// - Reset values: state=SYNC, sel_active=0, frame_cnt=0, line_cnt=0, last_lines=0,
//   m_tvalid=0, both s_tready=0 while rst=1.
// - Datapath is combinational; zero latency. tdata/tlast/tuser of the active source go straight to m_*.
// - SYNC state:
//   - Active tready=1 and m_tvalid=0; beats are discarded until the active source shows tvalid&tuser.
//   - That SOF beat is NOT consumed. Next state is PASS.
// - PASS state:
//   - m_tvalid = act.tvalid & ~gate.
//   - act.tready = m_tready & ~gate.
//   - gate = switch_pending & act.tvalid & act.tuser.
// - Switch event (PASS & gate):
//   - sel_active <= sel_req; state <= SYNC.
//   - The held SOF beat of the old source stays unconsumed.
// - switch_pending = (sel_req != sel_active). It is combinational, so a sel_req pulse that returns
//   before any SOF causes no switch.
// - Inactive source tready = DROP_INACTIVE, in every state.
// - Counters update on output handshake only (m_tvalid & m_tready):
//   - tuser beat: frame_cnt+1; last_lines <= line_cnt; line_cnt <= tlast ? 1 : 0.
//   - tlast beat without tuser: line_cnt+1, saturating at all-ones.
// - sel_req toggling mid-frame never truncates the current frame. The switch waits for the next SOF.
// - Active source idle forever: no switch occurs. This is a documented limitation.
// - Reset asserted mid-frame: everything returns to reset values immediately; resync to source 0.
// - frame_cnt wraps from all-ones to 0.
//
// STRUCTURE
// - Shared package tx_video_pkg holds:
//   - localparams SRC_LIVE=0 and SRC_SYNTH=1;
//   - the state encoding typedef {SYNC, PASS};
//   - the AXIS video beat struct {tdata, tlast, tuser}.
// - One sub-module, tx_frame_stats: owns frame_cnt, line_cnt and last_lines.
//   - Inputs: the handshake strobe, tuser and tlast.
// - Top level holds the FSM and the muxes.
//
// TESTING
// 1. Reset, sel_req=0, s0 sends 3 frames of 4 lines x 8 px, m_tready=1
//    -> 96 beats out, frame_cnt=3, last_lines=4.
// 2. s0 starts mid-frame (no SOF for 20 beats)
//    -> those 20 beats dropped, m_tvalid=0 until the SOF; first output beat has tuser=1.
// 3. sel_req 0->1 at line 2 of a frame
//    -> switch_pending=1; frame finishes from s0; s0 next SOF not consumed;
//       the first s1 SOF is the next output beat; sel_active=1.
// 4. sel_req pulses 0->1->0 within a frame
//    -> no switch, sel_active stays 0, frame_cnt unchanged vs. no-pulse run.
// 5. m_tready random 50% with DROP_INACTIVE=0
//    -> output equals the active-source sequence bit-exact; inactive tready=0 throughout.
// 6. rst asserted mid-line of the s1 frame
//    -> outputs at reset values next cycle; after release, resync on the next s0 SOF.

Source files
------------

// File: rtl/tx_video_pkg.sv
// Shared definitions for the Tx video scheduling path: source ids, scheduler
// state encoding and the AXI4-Stream video beat carried through the muxes.
package tx_video_pkg;

    localparam logic SRC_LIVE   = 1'b0;
    localparam logic SRC_SYNTH  = 1'b1;
    localparam int   VID_DATA_W = 32;

    typedef enum logic [0:0] {
        SYNC = 1'b0,
        PASS = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic [VID_DATA_W-1:0] tdata;
        logic                  tlast;
        logic                  tuser;
    } vid_beat_t;

endpackage

// File: rtl/tx_frame_sched_if.sv
// AXI4-Stream video link (tdata/tvalid/tready/tlast/tuser) used for both
// scheduler inputs and its output.
interface tx_frame_sched_if #(
    parameter int DATA_W = 32
) ();

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/tx_frame_stats.sv
// Frame statistics on the scheduler output: frames started, lines in the
// frame being sent, and line count of the previously completed frame.
module tx_frame_stats
    import tx_video_pkg::*;
#(
    parameter int FCNT_W = 16,
    parameter int LCNT_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hs_strobe,
    input  logic              tuser,
    input  logic              tlast,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic [LCNT_W-1:0] last_lines
);

    localparam logic [FCNT_W-1:0] FCNT_ONE  = {{(FCNT_W-1){1'b0}}, 1'b1};
    localparam logic [LCNT_W-1:0] LCNT_ONE  = {{(LCNT_W-1){1'b0}}, 1'b1};
    localparam logic [LCNT_W-1:0] LCNT_ZERO = {LCNT_W{1'b0}};
    localparam logic [LCNT_W-1:0] LCNT_MAX  = {LCNT_W{1'b1}};

    logic [FCNT_W-1:0] frame_cnt_r;
    logic [LCNT_W-1:0] line_cnt_r;
    logic [LCNT_W-1:0] last_lines_r;

    // Counters advance only on accepted output beats; an SOF that is also a
    // line end (one-line frame) opens the new frame already at one line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_r  <= {FCNT_W{1'b0}};
            line_cnt_r   <= LCNT_ZERO;
            last_lines_r <= LCNT_ZERO;
        end else if (hs_strobe && tuser) begin
            frame_cnt_r  <= frame_cnt_r + FCNT_ONE;
            last_lines_r <= line_cnt_r;
            line_cnt_r   <= tlast ? LCNT_ONE : LCNT_ZERO;
        end else if (hs_strobe && tlast && (line_cnt_r != LCNT_MAX)) begin
            line_cnt_r   <= line_cnt_r + LCNT_ONE;
        end
    end

    assign frame_cnt  = frame_cnt_r;
    assign last_lines = last_lines_r;

endmodule

// File: rtl/tx_frame_sched.sv
// Frame-aligned two-source scheduler for the Tx video output: source changes
// are taken only at a start-of-frame, so frames are never split.
module tx_frame_sched
    import tx_video_pkg::*;
#(
    parameter int DATA_W        = VID_DATA_W,
    parameter int FCNT_W        = 16,
    parameter int LCNT_W        = 12,
    parameter bit DROP_INACTIVE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel_req,
    tx_frame_sched_if.slave   s0_axis_video,
    tx_frame_sched_if.slave   s1_axis_video,
    tx_frame_sched_if.master  m_axis_video,
    output logic              sel_active,
    output logic              switch_pending,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic [LCNT_W-1:0] last_lines
);

    sched_state_e state_r;
    sched_state_e state_nxt_s;
    logic         sel_active_r;
    logic         sel_active_nxt_s;

    vid_beat_t    act_beat_s;
    logic         act_tvalid_s;
    logic         act_tready_s;
    logic         inact_tready_s;
    logic         switch_pending_s;
    logic         gate_s;
    logic         m_tvalid_s;
    logic         hs_s;

    // Active-source mux; the datapath is combinational end to end.
    always_comb begin
        act_beat_s   = '{tdata: {VID_DATA_W{1'b0}}, tlast: 1'b0, tuser: 1'b0};
        act_tvalid_s = 1'b0;
        if (sel_active_r == SRC_SYNTH) begin
            act_beat_s.tdata = VID_DATA_W'(s1_axis_video.tdata);
            act_beat_s.tlast = s1_axis_video.tlast;
            act_beat_s.tuser = s1_axis_video.tuser;
            act_tvalid_s     = s1_axis_video.tvalid;
        end else begin
            act_beat_s.tdata = VID_DATA_W'(s0_axis_video.tdata);
            act_beat_s.tlast = s0_axis_video.tlast;
            act_beat_s.tuser = s0_axis_video.tuser;
            act_tvalid_s     = s0_axis_video.tvalid;
        end
    end

    // A pending request only blocks the active source when it shows an SOF.
    assign switch_pending_s = (sel_req != sel_active_r);
    assign gate_s           = switch_pending_s & act_tvalid_s & act_beat_s.tuser;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= SYNC;
            sel_active_r <= SRC_LIVE;
        end else begin
            state_r      <= state_nxt_s;
            sel_active_r <= sel_active_nxt_s;
        end
    end

    // Next-state logic; ownership changes only on a gated SOF in PASS.
    always_comb begin
        state_nxt_s      = state_r;
        sel_active_nxt_s = sel_active_r;
        case (state_r)
            SYNC: begin
                if (act_tvalid_s && act_beat_s.tuser) begin
                    state_nxt_s = PASS;
                end else begin
                    state_nxt_s = SYNC;
                end
            end
            PASS: begin
                if (gate_s) begin
                    state_nxt_s      = SYNC;
                    sel_active_nxt_s = sel_req;
                end else begin
                    state_nxt_s      = PASS;
                end
            end
            default: begin
                state_nxt_s      = SYNC;
                sel_active_nxt_s = SRC_LIVE;
            end
        endcase
    end

    // Output logic; SYNC drains partial-frame beats but leaves the SOF in place.
    always_comb begin
        m_tvalid_s   = 1'b0;
        act_tready_s = 1'b0;
        case (state_r)
            SYNC: begin
                m_tvalid_s   = 1'b0;
                act_tready_s = ~(act_tvalid_s & act_beat_s.tuser);
            end
            PASS: begin
                m_tvalid_s   = act_tvalid_s & ~gate_s;
                act_tready_s = m_axis_video.tready & ~gate_s;
            end
            default: begin
                m_tvalid_s   = 1'b0;
                act_tready_s = 1'b0;
            end
        endcase
    end

    // Both sources are held off while reset is asserted.
    assign inact_tready_s = rst ? 1'b0 : DROP_INACTIVE;

    assign s0_axis_video.tready = rst ? 1'b0 :
                                  ((sel_active_r == SRC_LIVE)  ? act_tready_s : inact_tready_s);
    assign s1_axis_video.tready = rst ? 1'b0 :
                                  ((sel_active_r == SRC_SYNTH) ? act_tready_s : inact_tready_s);

    assign m_axis_video.tdata  = DATA_W'(act_beat_s.tdata);
    assign m_axis_video.tlast  = act_beat_s.tlast;
    assign m_axis_video.tuser  = act_beat_s.tuser;
    assign m_axis_video.tvalid = m_tvalid_s;

    assign hs_s = m_tvalid_s & m_axis_video.tready;

    tx_frame_stats #(
        .FCNT_W (FCNT_W),
        .LCNT_W (LCNT_W)
    ) u_stats (
        .clk        (clk),
        .rst        (rst),
        .hs_strobe  (hs_s),
        .tuser      (act_beat_s.tuser),
        .tlast      (act_beat_s.tlast),
        .frame_cnt  (frame_cnt),
        .last_lines (last_lines)
    );

    assign sel_active     = sel_active_r;
    assign switch_pending = switch_pending_s;

endmodule
